spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
- Shares one SPI byte engine (start / data_in / data_out / new_data, mode 0, MSB first) between N_REQ requesters.
- Each requester runs a multi-byte transaction under its own chip select.
- Arbitration is round-robin. The block sequences the chip select setup and hold time, issues one engine start per byte, and returns received bytes to the owning requester.
- A watchdog aborts a transaction if the engine stops responding.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- CS_DLY, 4, clk cycles of cs_n low before the first start and after the last byte (≥1)
- TIMEOUT, 1023, max clk cycles to wait for eng_new_data per byte before abort; 10-bit counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- req  in  N_REQ  per-requester transaction request, level
- len  in  4*N_REQ  per-requester byte count minus 1 (0 → 1 byte, 15 → 16 bytes); sampled at grant
- tx_data  in  8*N_REQ  per-requester current byte to send
- tx_ack  out  N_REQ  one-cycle pulse: current tx_data byte consumed, present next byte
- grant  out  N_REQ  one-hot owner, held for whole transaction
- cs_n  out  N_REQ  active-low chip selects, at most one low
- rx_data  out  8  last received byte
- rx_valid  out  N_REQ  one-cycle pulse to owner: rx_data valid
- done  out  N_REQ  one-cycle pulse to owner: transaction finished
- err  out  1  one-cycle pulse, coincident with done, when the transaction was aborted by watchdog
- eng_start  out  1  start pulse to engine
- eng_data_in  out  8  byte to engine
- eng_data_out  in  8  byte from engine
- eng_new_data  in  1  engine byte-complete pulse

Behaviour:
- All outputs registered.
- Reset values: grant=0, cs_n=all 1, tx_ack=0, rx_valid=0, done=0, err=0, eng_start=0, eng_data_in=0, rx_data=0. Round-robin pointer = 0.
- Reset asserted mid-transaction: everything returns to reset values immediately. No done is issued.
- State machine: IDLE → CS_SETUP → START → WAIT → (START | CS_HOLD) → GAP → IDLE.
- IDLE:
  - If any req is high, pick the first requester at or after the pointer (wrapping).
  - Latch its len into the byte counter.
  - Set grant, drive its cs_n low, and go to CS_SETUP.
  - Pointer becomes winner+1 mod N_REQ.
  - No req: stay; all outputs idle.
- CS_SETUP: count CS_DLY cycles with cs_n low, then go to START.
- START (exactly 1 cycle):
  - eng_start=1, eng_data_in=tx_data[owner], tx_ack[owner]=1.
  - Clear the watchdog; go to WAIT.
- WAIT:
  - Watchdog increments each cycle. eng_start=0.
  - On eng_new_data: rx_data=eng_data_out and rx_valid[owner]=1 on the next cycle.
    - If the byte counter is 0, go to CS_HOLD; else decrement and go to START.
  - Watchdog reaches TIMEOUT without eng_new_data: set the abort flag and go to CS_HOLD. No rx_valid.
  - eng_new_data and timeout in the same cycle: the data wins, no abort.
- CS_HOLD: cs_n stays low for CS_DLY cycles, then go to GAP.
- GAP (1 cycle):
  - cs_n all high, grant=0.
  - done[owner]=1; err=1 if the abort flag is set. Clear the abort flag.
  - Go to IDLE.
- Minimum cs_n high time between transactions: 2 cycles (GAP + IDLE).
- Inter-byte spacing: START follows the new_data cycle directly; cs_n stays low between bytes.
- Request handling:
  - req changes after grant are ignored; the transaction always runs to len+1 bytes or abort.
  - A requester drops req on seeing done (GAP) to avoid re-grant. req still high in IDLE means a new transaction.
  - req from non-owners is held pending; it does not affect the current transaction.
- eng_new_data outside WAIT is ignored.
- Widths:
  - Byte counter is 4 bit.
  - Watchdog saturates at TIMEOUT.
  - Pointer wraps N_REQ-1 → 0.

Test Plan:
- Single requester 0, len=2, tx bytes A5/3C/FF, engine model loops data back:
  - cs_n[0] low CS_DLY cycles before the first eng_start.
  - 3 tx_ack, 3 rx_valid with A5/3C/FF.
  - cs_n high after CS_DLY hold, done[0] once, err=0.
- req=2'b11 held continuously, each len=0:
  - Grants alternate 0,1,0,1.
  - cs_n never low on both, ≥2 high cycles between transactions.
- Engine model never pulses new_data, TIMEOUT=1023:
  - Abort 1023 cycles after eng_start.
  - No rx_valid; done and err pulse together; next requester served.
- len=15:
  - Exactly 16 eng_start pulses, byte counter wraps only at the end.
  - req dropped mid-transaction does not shorten it.
- rst asserted during WAIT of the second byte:
  - cs_n all high and grant=0 immediately; no done.
  - After release, a new req is granted from requester 0.
- eng_new_data pulse injected while IDLE / CS_SETUP: no rx_valid, no state change.

Source files
------------

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI byte engine between N_REQ requesters.
// Sequences chip-select setup/hold, issues one engine start per byte and aborts on engine silence.
module spi_arbiter #(
    parameter int N_REQ   = 2,
    parameter int CS_DLY  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [4*N_REQ-1:0]   len,
    input  logic [8*N_REQ-1:0]   tx_data,
    output logic [N_REQ-1:0]     tx_ack,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     cs_n,
    output logic [7:0]           rx_data,
    output logic [N_REQ-1:0]     rx_valid,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic                 eng_start,
    output logic [7:0]           eng_data_in,
    input  logic [7:0]           eng_data_out,
    input  logic                 eng_new_data
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW = (CS_DLY > 1) ? $clog2(CS_DLY) : 1;
    localparam logic [DW-1:0] DLY_LAST = DW'(CS_DLY - 1);
    localparam logic [9:0]    WD_LAST  = 10'(TIMEOUT - 1);
    localparam logic [9:0]    WD_MAX   = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_START,
        S_WAIT,
        S_CS_HOLD,
        S_GAP
    } state_t;

    state_t         state, state_d;
    logic [IW-1:0]  owner, owner_d;
    logic [IW-1:0]  ptr, ptr_d;
    logic [3:0]     byte_cnt, byte_cnt_d;
    logic [DW-1:0]  dly, dly_d;
    logic [9:0]     wd, wd_d;
    logic           abort_flag, abort_d;

    logic [N_REQ-1:0] grant_d, cs_n_d, tx_ack_d, rx_valid_d, done_d;
    logic [7:0]       rx_data_d, eng_data_in_d;
    logic             err_d, eng_start_d;

    logic [IW-1:0]    win;
    logic [IW-1:0]    ptr_next;
    logic [IW:0]      cand;
    logic             any_req;
    logic [N_REQ-1:0] win_oh;
    logic [7:0]       owner_byte;

    // First requesting index at or after the pointer, wrapping past N_REQ-1.
    always_comb begin
        win     = ptr;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_REQ)) begin
                cand = cand - (IW+1)'(N_REQ);
            end
            if (!any_req && req[cand[IW-1:0]]) begin
                any_req = 1'b1;
                win     = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    assign ptr_next   = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
    assign owner_byte = tx_data[{owner, 3'b000} +: 8];

    always_comb begin
        state_d       = state;
        owner_d       = owner;
        ptr_d         = ptr;
        byte_cnt_d    = byte_cnt;
        dly_d         = dly;
        wd_d          = wd;
        abort_d       = abort_flag;
        grant_d       = grant;
        cs_n_d        = cs_n;
        rx_data_d     = rx_data;
        eng_data_in_d = eng_data_in;
        tx_ack_d      = '0;
        rx_valid_d    = '0;
        done_d        = '0;
        err_d         = 1'b0;
        eng_start_d   = 1'b0;

        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_d    = S_CS_SETUP;
                    owner_d    = win;
                    ptr_d      = ptr_next;
                    byte_cnt_d = len[{win, 2'b00} +: 4];
                    grant_d    = win_oh;
                    cs_n_d     = ~win_oh;
                    dly_d      = '0;
                end
            end

            S_CS_SETUP: begin
                if (dly == DLY_LAST) begin
                    state_d       = S_START;
                    eng_start_d   = 1'b1;
                    eng_data_in_d = owner_byte;
                    tx_ack_d      = grant;
                end else begin
                    dly_d = dly + DW'(1);
                end
            end

            S_START: begin
                state_d = S_WAIT;
                wd_d    = '0;
            end

            // A byte arriving on the last watchdog cycle still counts as data.
            S_WAIT: begin
                if (eng_new_data) begin
                    rx_data_d  = eng_data_out;
                    rx_valid_d = grant;
                    if (byte_cnt == 4'd0) begin
                        state_d = S_CS_HOLD;
                        dly_d   = '0;
                    end else begin
                        byte_cnt_d    = byte_cnt - 4'd1;
                        state_d       = S_START;
                        eng_start_d   = 1'b1;
                        eng_data_in_d = owner_byte;
                        tx_ack_d      = grant;
                    end
                end else if (wd == WD_LAST) begin
                    wd_d    = WD_MAX;
                    abort_d = 1'b1;
                    state_d = S_CS_HOLD;
                    dly_d   = '0;
                end else if (wd != WD_MAX) begin
                    wd_d = wd + 10'd1;
                end
            end

            S_CS_HOLD: begin
                if (dly == DLY_LAST) begin
                    state_d = S_GAP;
                    cs_n_d  = '1;
                    grant_d = '0;
                    done_d  = grant;
                    err_d   = abort_flag;
                    abort_d = 1'b0;
                end else begin
                    dly_d = dly + DW'(1);
                end
            end

            S_GAP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            owner       <= '0;
            ptr         <= '0;
            byte_cnt    <= '0;
            dly         <= '0;
            wd          <= '0;
            abort_flag  <= 1'b0;
            grant       <= '0;
            cs_n        <= '1;
            tx_ack      <= '0;
            rx_valid    <= '0;
            done        <= '0;
            err         <= 1'b0;
            eng_start   <= 1'b0;
            eng_data_in <= '0;
            rx_data     <= '0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            ptr         <= ptr_d;
            byte_cnt    <= byte_cnt_d;
            dly         <= dly_d;
            wd          <= wd_d;
            abort_flag  <= abort_d;
            grant       <= grant_d;
            cs_n        <= cs_n_d;
            tx_ack      <= tx_ack_d;
            rx_valid    <= rx_valid_d;
            done        <= done_d;
            err         <= err_d;
            eng_start   <= eng_start_d;
            eng_data_in <= eng_data_in_d;
            rx_data     <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: loopback engine model, requester models and a
// scoreboard of expected received bytes and completions.
module tb_spi_arbiter;

    localparam int N       = 2;
    localparam int CS_DLY  = 4;
    localparam int TIMEOUT = 1023;
    localparam int ENG_LAT = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [4*N-1:0] len = '0;
    logic [8*N-1:0] tx_data = '0;
    logic [N-1:0]   tx_ack, grant, cs_n, rx_valid, done;
    logic [7:0]     rx_data, eng_data_in;
    logic           err, eng_start;
    logic [7:0]     eng_data_out = '0;
    logic           eng_new_data = 1'b0;

    always #5 clk = ~clk;

    spi_arbiter #(.N_REQ(N), .CS_DLY(CS_DLY), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .tx_data(tx_data),
        .tx_ack(tx_ack), .grant(grant), .cs_n(cs_n), .rx_data(rx_data),
        .rx_valid(rx_valid), .done(done), .err(err), .eng_start(eng_start),
        .eng_data_in(eng_data_in), .eng_data_out(eng_data_out),
        .eng_new_data(eng_new_data)
    );

    typedef struct packed { logic [1:0] who; logic [7:0] data; } rx_exp_t;
    typedef struct packed { logic [1:0] who; logic err; } done_exp_t;
    typedef struct packed {
        int       who;
        logic [3:0] blen;
        logic [7:0] b0;
        logic [7:0] stp;
        int       exp_starts;
    } vec_t;

    rx_exp_t   rx_q[$];
    done_exp_t done_q[$];
    int        grant_log[$];

    int vecs_applied = 0;
    int miscompares  = 0;
    int cyc = 0;
    int n_start = 0, n_ack = 0, n_rx = 0, n_done = 0;
    logic [7:0] txb [N][16];
    int  txi [N];
    bit  autodrop [N];
    int  eng_cd = 0;
    logic [7:0] eng_byte = '0;
    int  mute_n = 0;
    bit  inj = 1'b0;
    logic [N-1:0] prev_grant = '0, prev_cs_n = '1;
    int  hi_run = 0;
    bit  seen_txn = 1'b0, pend_first = 1'b0;
    int  last_cs_fall = 0, last_cs_rise = 0, first_start_cyc = 0, last_rx_cyc = 0, last_done_cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample outputs 1ns after the edge, then update the engine/requester models.
    task automatic step();
        rx_exp_t   re;
        done_exp_t de;
        @(posedge clk);
        #1;
        cyc++;
        checkOutput("cs_n_onehot", 32'($countones(~cs_n) <= 1), 1);
        if (rx_valid != 0) begin
            n_rx++;
            last_rx_cyc = cyc;
            if (rx_q.size() == 0) checkOutput("rx_unexpected", 32'(rx_valid), 0);
            else begin
                re = rx_q.pop_front();
                checkOutput("rx_valid_owner", 32'(rx_valid), 32'(1) << re.who);
                checkOutput("rx_data", 32'(rx_data), 32'(re.data));
            end
        end
        if (err && done == 0) checkOutput("err_without_done", 32'(err), 0);
        if (done != 0) begin
            n_done++;
            last_done_cyc = cyc;
            if (done_q.size() == 0) checkOutput("done_unexpected", 32'(done), 0);
            else begin
                de = done_q.pop_front();
                checkOutput("done_owner", 32'(done), 32'(1) << de.who);
                checkOutput("err_flag", 32'(err), 32'(de.err));
            end
        end
        if (eng_start) begin
            n_start++;
            if (pend_first) begin
                first_start_cyc = cyc;
                pend_first = 1'b0;
            end
            if (mute_n > 0) mute_n--;
            else begin
                eng_cd   = ENG_LAT;
                eng_byte = eng_data_in;
            end
        end
        n_ack += $countones(tx_ack);
        if (cs_n == '1) begin
            if (prev_cs_n != '1) last_cs_rise = cyc;
            hi_run++;
        end else begin
            if (prev_cs_n == '1) begin
                last_cs_fall = cyc;
                pend_first   = 1'b1;
                if (seen_txn) checkOutput("cs_high_gap", 32'(hi_run >= 2), 1);
                seen_txn = 1'b1;
            end
            hi_run = 0;
        end
        if (grant != 0 && prev_grant == 0) grant_log.push_back(grant[1] ? 1 : 0);
        prev_grant = grant;
        prev_cs_n  = cs_n;

        eng_new_data = 1'b0;
        if (eng_cd > 0) begin
            eng_cd--;
            if (eng_cd == 0) begin
                eng_new_data = 1'b1;
                eng_data_out = eng_byte;
            end
        end
        if (inj) begin
            eng_new_data = 1'b1;
            eng_data_out = 8'hEE;
            inj = 1'b0;
        end
        for (int r = 0; r < N; r++) begin
            if (tx_ack[r]) begin
                if (txi[r] < 15) txi[r]++;
                tx_data[8*r +: 8] = txb[r][txi[r]];
            end
            if (done[r]) begin
                txi[r] = 0;
                tx_data[8*r +: 8] = txb[r][0];
                if (autodrop[r]) req[r] = 1'b0;
            end
        end
    endtask

    task automatic fillBytes(input int r, input logic [7:0] b0, input logic [7:0] stp);
        for (int k = 0; k < 16; k++) txb[r][k] = b0 + 8'(k) * stp;
    endtask

    task automatic pushTxn(input int r, input logic [3:0] l, input logic aborted);
        if (!aborted)
            for (int k = 0; k <= int'(l); k++) rx_q.push_back('{who: 2'(r), data: txb[r][k]});
        done_q.push_back('{who: 2'(r), err: aborted});
    endtask

    task automatic armReq(input int r, input logic [3:0] l);
        len[4*r +: 4]     = l;
        txi[r]            = 0;
        tx_data[8*r +: 8] = txb[r][0];
        req[r]            = 1'b1;
    endtask

    task automatic waitDone(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            step();
            k++;
        end
        if (n_done < target) checkOutput("wait_done_budget", 32'(n_done), 32'(target));
    endtask

    task automatic resetDut();
        rst = 1'b0;
        req = '0;
        inj = 1'b0;
        eng_cd = 0;
        mute_n = 0;
        eng_new_data = 1'b0;
        step();
        step();
        rx_q.delete();
        done_q.delete();
        grant_log.delete();
        seen_txn = 1'b0;
        pend_first = 1'b0;
        hi_run = 0;
        for (int r = 0; r < N; r++) begin
            txi[r] = 0;
            autodrop[r] = 1'b1;
        end
        rst = 1'b1;
        step();
        step();
    endtask

    task automatic applyStimulus(input vec_t v);
        int s0 = n_start, a0 = n_ack, r0 = n_rx, d0 = n_done;
        fillBytes(v.who, v.b0, v.stp);
        pushTxn(v.who, v.blen, 1'b0);
        armReq(v.who, v.blen);
        waitDone(d0 + 1, 200);
        checkOutput("vec_starts", 32'(n_start - s0), 32'(v.exp_starts));
        checkOutput("vec_acks", 32'(n_ack - a0), 32'(v.exp_starts));
        checkOutput("vec_rx", 32'(n_rx - r0), 32'(v.exp_starts));
        if (grant_log.size() > 0) checkOutput("vec_owner", 32'(grant_log[grant_log.size()-1]), 32'(v.who));
        else checkOutput("vec_owner_missing", 0, 1);
        step();
        step();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_time_limit: simulation did not finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        vec_t vecs [5];
        int s0, a0, r0, d0, k;

        vecs[0] = '{who: 0, blen: 4'd0,  b0: 8'h5A, stp: 8'h01, exp_starts: 1};
        vecs[1] = '{who: 1, blen: 4'd1,  b0: 8'h10, stp: 8'h21, exp_starts: 2};
        vecs[2] = '{who: 1, blen: 4'd3,  b0: 8'hF0, stp: 8'h07, exp_starts: 4};
        vecs[3] = '{who: 0, blen: 4'd7,  b0: 8'h00, stp: 8'h33, exp_starts: 8};
        vecs[4] = '{who: 1, blen: 4'd15, b0: 8'h80, stp: 8'h11, exp_starts: 16};

        for (int r = 0; r < N; r++) begin
            txi[r] = 0;
            autodrop[r] = 1'b1;
            fillBytes(r, 8'h00, 8'h00);
        end

        // Reset values while rst is held low.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_cs_n", 32'(cs_n), 32'(2'b11));
        checkOutput("rst_tx_ack", 32'(tx_ack), 0);
        checkOutput("rst_rx_valid", 32'(rx_valid), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_eng_start", 32'(eng_start), 0);
        checkOutput("rst_eng_data_in", 32'(eng_data_in), 0);
        checkOutput("rst_rx_data", 32'(rx_data), 0);
        rst = 1'b1;
        step();
        step();

        $display("[TB] single requester, bytes A5/3C/FF");
        s0 = n_start; a0 = n_ack; r0 = n_rx; d0 = n_done;
        txb[0][0] = 8'hA5; txb[0][1] = 8'h3C; txb[0][2] = 8'hFF;
        pushTxn(0, 4'd2, 1'b0);
        armReq(0, 4'd2);
        waitDone(d0 + 1, 200);
        checkOutput("seq1_starts", 32'(n_start - s0), 3);
        checkOutput("seq1_acks", 32'(n_ack - a0), 3);
        checkOutput("seq1_rx", 32'(n_rx - r0), 3);
        checkOutput("seq1_cs_setup", 32'(first_start_cyc - last_cs_fall), CS_DLY);
        checkOutput("seq1_cs_hold", 32'(last_cs_rise - last_rx_cyc), CS_DLY);
        checkOutput("seq1_done_at_cs_rise", 32'(last_done_cyc), 32'(last_cs_rise));
        step();
        step();
        checkOutput("seq1_single_done", 32'(n_done - d0), 1);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        $display("[TB] len=15 with req dropped mid-transaction");
        s0 = n_start; r0 = n_rx; d0 = n_done; a0 = n_ack;
        fillBytes(0, 8'h01, 8'h0F);
        pushTxn(0, 4'd15, 1'b0);
        armReq(0, 4'd15);
        k = 0;
        while (n_ack < a0 + 3 && k < 100) begin
            step();
            k++;
        end
        req[0] = 1'b0;
        waitDone(d0 + 1, 300);
        checkOutput("len15_starts", 32'(n_start - s0), 16);
        checkOutput("len15_rx", 32'(n_rx - r0), 16);
        step();
        step();

        $display("[TB] both requesting continuously");
        resetDut();
        autodrop[0] = 1'b0;
        autodrop[1] = 1'b0;
        fillBytes(0, 8'h11, 8'h00);
        fillBytes(1, 8'h22, 8'h00);
        for (int j = 0; j < 2; j++) begin
            pushTxn(0, 4'd0, 1'b0);
            pushTxn(1, 4'd0, 1'b0);
        end
        d0 = n_done;
        armReq(0, 4'd0);
        armReq(1, 4'd0);
        waitDone(d0 + 4, 300);
        req = '0;
        repeat (4) step();
        checkOutput("alt_grant_count", 32'(grant_log.size()), 4);
        for (int j = 0; j < 4 && j < grant_log.size(); j++)
            checkOutput($sformatf("alt_grant_%0d", j), 32'(grant_log[j]), 32'(j % 2));

        $display("[TB] silent engine watchdog");
        resetDut();
        fillBytes(0, 8'h77, 8'h00);
        fillBytes(1, 8'h99, 8'h00);
        pushTxn(0, 4'd0, 1'b1);
        pushTxn(1, 4'd0, 1'b0);
        mute_n = 1;
        r0 = n_rx; d0 = n_done;
        armReq(0, 4'd0);
        armReq(1, 4'd0);
        waitDone(d0 + 1, 2000);
        checkOutput("wd_abort_latency", 32'(last_done_cyc - first_start_cyc), TIMEOUT + CS_DLY + 1);
        checkOutput("wd_no_rx", 32'(n_rx - r0), 0);
        waitDone(d0 + 2, 200);
        checkOutput("wd_next_owner", 32'(grant_log[grant_log.size()-1]), 1);
        checkOutput("wd_next_rx", 32'(n_rx - r0), 1);
        step();
        step();

        $display("[TB] reset during second byte");
        resetDut();
        fillBytes(0, 8'h40, 8'h01);
        pushTxn(0, 4'd3, 1'b0);
        s0 = n_start;
        armReq(0, 4'd3);
        k = 0;
        while (n_start < s0 + 2 && k < 100) begin
            step();
            k++;
        end
        step();
        rst = 1'b0;
        #1;
        checkOutput("midrst_cs_n", 32'(cs_n), 32'(2'b11));
        checkOutput("midrst_grant", 32'(grant), 0);
        checkOutput("midrst_eng_start", 32'(eng_start), 0);
        rx_q.delete();
        done_q.delete();
        req = '0;
        eng_cd = 0;
        d0 = n_done;
        repeat (3) step();
        rst = 1'b1;
        step();
        step();
        checkOutput("midrst_no_done", 32'(n_done - d0), 0);
        fillBytes(0, 8'hC0, 8'h00);
        fillBytes(1, 8'hD0, 8'h00);
        pushTxn(0, 4'd0, 1'b0);
        pushTxn(1, 4'd0, 1'b0);
        k = grant_log.size();
        armReq(0, 4'd0);
        armReq(1, 4'd0);
        waitDone(d0 + 2, 200);
        if (grant_log.size() >= k + 2) begin
            checkOutput("midrst_first_owner", 32'(grant_log[k]), 0);
            checkOutput("midrst_second_owner", 32'(grant_log[k+1]), 1);
        end else checkOutput("midrst_grant_count", 32'(grant_log.size() - k), 2);
        step();
        step();

        $display("[TB] stray engine pulses in IDLE and CS_SETUP");
        resetDut();
        r0 = n_rx; d0 = n_done;
        inj = 1'b1;
        repeat (3) step();
        checkOutput("inj_idle_grant", 32'(grant), 0);
        checkOutput("inj_idle_cs_n", 32'(cs_n), 32'(2'b11));
        checkOutput("inj_idle_rx", 32'(n_rx - r0), 0);
        fillBytes(1, 8'h42, 8'h00);
        pushTxn(1, 4'd0, 1'b0);
        armReq(1, 4'd0);
        step();
        checkOutput("inj_setup_grant", 32'(grant), 32'(2'b10));
        inj = 1'b1;
        waitDone(d0 + 1, 200);
        checkOutput("inj_setup_timing", 32'(first_start_cyc - last_cs_fall), CS_DLY);
        checkOutput("inj_setup_rx", 32'(n_rx - r0), 1);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs_applied, miscompares);
        $finish;
    end

endmodule
